// File: rtl/scheduler_pkg.sv
// Shared types and widths for the attack scheduler and its helpers.
package scheduler_pkg;

    localparam int HP_W  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4,
        S_DEAD = 3'd5
    } state_t;

    // Successor of pattern p, wrapping at np.
    function automatic logic [IDX_W-1:0] wrap_next(input logic [IDX_W-1:0] p, input int np);
        return (int'(p) == np - 1) ? '0 : p + IDX_W'(1);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running game-tick prescaler; clear restarts the phase so the
// first tick lands TICK_DIV cycles after the clear cycle.
module tick_divider #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= RELOAD;
        else if (clear || cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - CNT_W'(1);
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/attack_scheduler.sv
// Enemy attack-phase sequencer: pattern pair selection, bullet run gating
// and rate-limited player damage.
module attack_scheduler
    import scheduler_pkg::*;
#(
    parameter int TICK_DIV      = 1_000_000,
    parameter int PATTERN_TICKS = 300,
    parameter int GAP_TICKS     = 30,
    parameter int NUM_PATTERNS  = 8,
    parameter int MAX_HP        = 20,
    parameter int DAMAGE        = 4,
    parameter int INVULN_TICKS  = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isCollide,
    output logic [IDX_W-1:0] index1,
    output logic [IDX_W-1:0] index2,
    output logic             isRun,
    output logic             bulletCollide,
    output logic [HP_W-1:0]  hp,
    output logic             hitPulse,
    output logic             done,
    output logic             dead
);
    // state | meaning
    // IDLE  | waiting for the first start after reset
    // ARM   | pattern pair loaded, bullets frozen for one cycle
    // RUN   | bullets moving, hits accepted
    // GAP   | bullets frozen between patterns
    // DONE  | every pattern survived
    // DEAD  | an accepted hit emptied hp

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PATTERN_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_TICKS);
    localparam logic [HP_W-1:0]  HP_MAX   = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0]  HP_DMG   = HP_W'(DAMAGE);

    state_t           state, state_nx;
    logic             tick, collide_q, hit, go, pat_end, gap_end, last_pat, die;
    logic [CNT_W-1:0] tick_cnt, inv_cnt;
    logic [IDX_W-1:0] p;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (go || state == S_ARM),
        .tick  (tick)
    );

    // A pending death outranks a restart in DONE.
    assign die      = hitPulse && (hp == '0);
    assign go       = start && !die && (state inside {S_IDLE, S_DONE, S_DEAD});
    assign hit      = (state == S_RUN) && isCollide && !collide_q && (inv_cnt == '0);
    assign pat_end  = (state == S_RUN) && tick && (tick_cnt == '0);
    assign gap_end  = (state == S_GAP) && tick && (tick_cnt == '0);
    assign last_pat = (int'(p) == NUM_PATTERNS - 1);
    assign bulletCollide = hitPulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        isRun    = 1'b0;
        done     = 1'b0;
        dead     = 1'b0;
        case (state)
            S_IDLE: if (go) state_nx = S_ARM;
            S_ARM:  state_nx = S_RUN;
            S_RUN: begin
                isRun = 1'b1;
                if (pat_end) state_nx = last_pat ? S_DONE : S_GAP;
            end
            S_GAP:  if (gap_end) state_nx = S_ARM;
            S_DONE: begin
                done = 1'b1;
                if (go) state_nx = S_ARM;
            end
            S_DEAD: begin
                dead = 1'b1;
                if (go) state_nx = S_ARM;
            end
            default: state_nx = S_IDLE;
        endcase
        if (die) state_nx = S_DEAD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collide_q <= 1'b0;
            hitPulse  <= 1'b0;
            hp        <= HP_MAX;
            p         <= '0;
            index1    <= '0;
            index2    <= '0;
            tick_cnt  <= '0;
            inv_cnt   <= '0;
        end else begin
            collide_q <= isCollide;
            hitPulse  <= hit;

            if (go)
                hp <= HP_MAX;
            else if (hit)
                hp <= (hp > HP_DMG) ? hp - HP_DMG : '0;

            if (go)
                inv_cnt <= '0;
            else if (hit)
                inv_cnt <= INV_LOAD;
            else if (tick && inv_cnt != '0)
                inv_cnt <= inv_cnt - CNT_W'(1);

            if (go) begin
                p      <= '0;
                index1 <= '0;
                index2 <= wrap_next('0, NUM_PATTERNS);
            end else if (gap_end) begin
                p      <= wrap_next(p, NUM_PATTERNS);
                index1 <= wrap_next(p, NUM_PATTERNS);
                index2 <= wrap_next(wrap_next(p, NUM_PATTERNS), NUM_PATTERNS);
            end

            if (go)
                tick_cnt <= '0;
            else if (state == S_ARM)
                tick_cnt <= PAT_LAST;
            else if (pat_end)
                tick_cnt <= GAP_LAST;
            else if (tick && tick_cnt != '0 && (state == S_RUN || state == S_GAP))
                tick_cnt <= tick_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_attack_scheduler.sv
// Self-checking bench for attack_scheduler against a schedule-arithmetic model.
module tb_attack_scheduler;

    localparam int TD  = 4;
    localparam int PT  = 10;
    localparam int GT  = 2;
    localparam int NP  = 3;
    localparam int MHP = 20;
    localparam int DMG = 5;
    localparam int INV = 6;

    // A phase as a timeline, in cycles after the start edge (edge 0):
    // edge 0 enters ARM of pattern 0; pattern k runs for P_CYC cycles,
    // then GAP for G_CYC cycles, then one ARM cycle for pattern k+1.
    localparam int P_CYC = PT * TD;
    localparam int G_CYC = GT * TD;
    localparam int L_CYC = 1 + P_CYC + G_CYC;

    localparam int K_ARM = 0, K_RUN = 1, K_GAP = 2, K_DONE = 3, K_NONE = 4;
    localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2, M_DEAD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       isCollide = 1'b0;
    logic [2:0] index1, index2;
    logic       isRun, bulletCollide, hitPulse, done, dead;
    logic [7:0] hp;

    int n_chk = 0;
    int n_pass = 0;

    attack_scheduler #(
        .TICK_DIV(TD), .PATTERN_TICKS(PT), .GAP_TICKS(GT), .NUM_PATTERNS(NP),
        .MAX_HP(MHP), .DAMAGE(DMG), .INVULN_TICKS(INV)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .isCollide(isCollide),
        .index1(index1), .index2(index2), .isRun(isRun),
        .bulletCollide(bulletCollide), .hp(hp), .hitPulse(hitPulse),
        .done(done), .dead(dead)
    );

    always #5 clk = ~clk;

    function automatic int kind_of(input int t);
        int k, r;
        if (t == 0) return K_ARM;
        k = (t - 1) / L_CYC;
        r = (t - 1) % L_CYC;
        if (k > NP - 1 || (k == NP - 1 && r >= P_CYC)) return K_DONE;
        if (r < P_CYC) return K_RUN;
        if (r < P_CYC + G_CYC) return K_GAP;
        return K_ARM;
    endfunction

    function automatic int pat_of(input int t);
        if (t == 0) return 0;
        return (t - 1) / L_CYC + (((t - 1) % L_CYC == P_CYC + G_CYC) ? 1 : 0);
    endfunction

    int m_mode = M_IDLE, m_t = 0, m_hp = MHP, m_inv = 0, m_i1 = 0, m_i2 = 0;
    int m_cur = K_NONE, ecount = 0, last_clear = 0;
    bit m_hit = 0, m_pend = 0, m_collq = 0, m_tick = 0, m_hitnow = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_mode = M_IDLE; m_t = 0; m_hp = MHP; m_inv = 0; m_i1 = 0; m_i2 = 0;
            m_hit = 0; m_pend = 0; m_collq = 0; last_clear = ecount;
        end else begin
            m_cur    = (m_mode == M_ACT) ? kind_of(m_t) : K_NONE;
            ecount   = ecount + 1;
            m_tick   = ((ecount - last_clear) % TD) == 0;
            m_hitnow = (m_cur == K_RUN) && isCollide && !m_collq && (m_inv == 0);
            m_collq  = isCollide;
            if (m_cur == K_ARM) last_clear = ecount;
            if (m_hitnow) begin
                m_hp  = (m_hp > DMG) ? m_hp - DMG : 0;
                m_inv = INV;
            end else if (m_tick && m_inv > 0) begin
                m_inv = m_inv - 1;
            end
            m_hit = m_hitnow;
            if (m_pend) begin
                m_mode = M_DEAD;
            end else if (m_mode != M_ACT && start) begin
                m_mode = M_ACT; m_t = 0; m_hp = MHP; m_inv = 0;
                last_clear = ecount; m_i1 = 0; m_i2 = 1 % NP;
            end else if (m_mode == M_ACT) begin
                m_t = m_t + 1;
                if (kind_of(m_t) == K_DONE) m_mode = M_DONE;
                else if (kind_of(m_t) == K_ARM) begin
                    m_i1 = pat_of(m_t);
                    m_i2 = (m_i1 + 1) % NP;
                end
            end
            m_pend = m_hitnow && (m_hp == 0);
        end
    end

    wire  [18:0] dut_vec = {isRun, index1, index2, hp, hitPulse, bulletCollide, done, dead};
    logic [18:0] mdl_vec;
    always @* mdl_vec = {(m_mode == M_ACT && kind_of(m_t) == K_RUN), 3'(m_i1), 3'(m_i2), 8'(m_hp),
                         m_hit, m_hit, (m_mode == M_DONE), (m_mode == M_DEAD)};

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== 19'({1'b0, 3'd0, 3'd0, 8'd20, 4'b0000}))
                $display("FAIL reset_values cyc %0d: got %h want %h", i, dut_vec, {1'b0, 3'd0, 3'd0, 8'd20, 4'b0000});
            else n_pass++;
            n_chk++;
            if (dut_vec !== mdl_vec) $display("FAIL reset_model cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    task automatic test_schedule();
        int runs = 0;
        int first_run = -1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec) $display("FAIL schedule cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            else n_pass++;
            if (isRun === 1'b1) begin
                runs++;
                if (first_run < 0) first_run = i;
            end
            // The second start lands on the DONE-entry edge and must be ignored.
            start = (i == 0) || (i == 139);
            isCollide = 1'b0;
        end
        n_chk++;
        if (runs != NP * P_CYC) $display("FAIL run_cycles: got %0d want %0d", runs, NP * P_CYC);
        else n_pass++;
        n_chk++;
        if (first_run != 2) $display("FAIL run_latency: got %0d want 2", first_run);
        else n_pass++;
        n_chk++;
        if (done !== 1'b1 || isRun !== 1'b0) $display("FAIL done_after_phase: got done=%b run=%b want 1 0", done, isRun);
        else n_pass++;
    endtask

    task automatic test_hold();
        int hits = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec) $display("FAIL hold cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            else n_pass++;
            if (hitPulse === 1'b1) hits++;
            start = (i == 0);
            isCollide = (i >= 3 && i <= 102);
        end
        n_chk++;
        if (hits != 1) $display("FAIL hold_hits: got %0d want 1", hits);
        else n_pass++;
        n_chk++;
        if (hp !== 8'd15) $display("FAIL hold_hp: got %0d want 15", hp);
        else n_pass++;
    endtask

    task automatic test_invuln();
        int hits = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec) $display("FAIL invuln cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            else n_pass++;
            if (hitPulse === 1'b1) hits++;
            start = (i == 0);
            // 5: hit, 17: inside window, 35: after window, 44: GAP, 145/150: DONE
            isCollide = (i >= 5 && i < 8) || (i >= 17 && i < 20) || (i >= 35 && i < 38) ||
                        (i >= 44 && i < 46) || (i >= 145 && i < 147) || (i >= 150 && i < 152);
        end
        n_chk++;
        if (hits != 2) $display("FAIL invuln_hits: got %0d want 2", hits);
        else n_pass++;
        n_chk++;
        if (hp !== 8'd10) $display("FAIL invuln_hp: got %0d want 10", hp);
        else n_pass++;
    endtask

    task automatic test_death();
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec) $display("FAIL death cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            else n_pass++;
            start = (i == 0);
            isCollide = (i >= 25 && i < 28) || (i >= 55 && i < 58) || (i >= 85 && i < 88) ||
                        (i >= 115 && i < 118) || (i >= 125 && i < 128) || (i >= 135 && i < 138);
        end
        n_chk++;
        if ({hp, dead, isRun} !== {8'd0, 1'b1, 1'b0})
            $display("FAIL death_final: got hp=%0d dead=%b run=%b want 0 1 0", hp, dead, isRun);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 61; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec) $display("FAIL pre_reset cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            else n_pass++;
            if (i == 58) begin
                n_chk++;
                if (hp !== 8'd10 || index1 !== 3'd1 || isRun !== 1'b1)
                    $display("FAIL pre_reset_state: got hp=%0d i1=%0d run=%b want 10 1 1", hp, index1, isRun);
                else n_pass++;
            end
            start = (i == 0);
            isCollide = (i >= 25 && i < 28) || (i >= 55 && i < 58);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({isRun, hp, done, dead, index1, index2, hitPulse} !== {1'b0, 8'd20, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0})
            $display("FAIL async_reset: got run=%b hp=%0d done=%b dead=%b i1=%0d i2=%0d hit=%b want 0 20 0 0 0 0 0",
                     isRun, hp, done, dead, index1, index2, hitPulse);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec) $display("FAIL restart cyc %0d: got %h want %h", i, dut_vec, mdl_vec);
            else n_pass++;
            if (i == 3) begin
                n_chk++;
                if ({isRun, index1, index2} !== {1'b1, 3'd0, 3'd1})
                    $display("FAIL restart_pattern: got run=%b i1=%0d i2=%0d want 1 0 1", isRun, index1, index2);
                else n_pass++;
            end
            start = (i == 0);
            isCollide = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                n_chk++;
                if (dut_vec !== mdl_vec) $display("FAIL random ph %0d cyc %0d: got %h want %h", ph, i, dut_vec, mdl_vec);
                else n_pass++;
                start = (i == 0) || ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 5) == 0) isCollide = ~isCollide;
            end
        end
        start = 1'b0;
        isCollide = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        test_reset();
        test_schedule();
        test_hold();
        test_invuln();
        test_death();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/attack_scheduler.md
# attack_scheduler

Sequences the enemy attack phase of the fight screen by driving the Bullet datapath: selects the bullet pattern pair (`index1`/`index2`), gates bullet motion (`isRun`), and turns raw player/bullet collisions into rate-limited damage on the player HP register. It sits between the game-state controller, which issues `start`, and the Bullet block plus the HP display. It reports phase completion or player death back to the game-state controller.

## Interface
- `TICK_DIV`, 1_000_000: clk cycles per game tick.
- `PATTERN_TICKS`, 300: ticks each pattern pair runs.
- `GAP_TICKS`, 30: ticks with bullets frozen between patterns.
- `NUM_PATTERNS`, 8: patterns per phase, range 1..8.
- `MAX_HP`, 20: HP after reset and at every `start`.
- `DAMAGE`, 4: HP removed per accepted hit.
- `INVULN_TICKS`, 60: hit-immunity window after an accepted hit.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a phase. Ignored outside IDLE, DONE and DEAD.
- `isCollide` in 1: level from the collision detector.
- `index1` out 3: pattern select for bullet 1.
- `index2` out 3: pattern select for bullet 2.
- `isRun` out 1: bullet motion enable.
- `bulletCollide` out 1: one-cycle pulse to the Bullet `isCollide` input on each accepted hit.
- `hp` out 8: current player HP.
- `hitPulse` out 1: one-cycle pulse on each accepted hit.
- `done` out 1: high while in DONE.
- `dead` out 1: high while in DEAD.

## Operation
- FSM states: IDLE, ARM, RUN, GAP, DONE, DEAD.
- IDLE / DONE / DEAD + `start`:
  - `hp` ← MAX_HP, pattern counter `p` ← 0, tick and invulnerability counters cleared.
  - Next state ARM.
- ARM, one cycle:
  - `index1` ← `p`; `index2` ← (`p`+1) mod NUM_PATTERNS; `isRun` = 0.
  - Then RUN.
  - Indices are registered, so they are stable before `isRun` rises.
- RUN:
  - `isRun` = 1; count ticks.
  - On the PATTERN_TICKS-th tick: if `p` = NUM_PATTERNS−1 go to DONE, else go to GAP.
- GAP:
  - `isRun` = 0.
  - After GAP_TICKS ticks: `p` ← `p`+1, go to ARM.
- DONE / DEAD: `isRun` = 0; indices hold their last values.
- Hit acceptance:
  - A hit is a rising edge of `isCollide` (compared against a registered copy of the previous cycle), in RUN, with the invulnerability counter = 0.
  - On a hit: `hp` ← max(`hp`−DAMAGE, 0); `hitPulse` and `bulletCollide` high for one cycle; invulnerability counter ← INVULN_TICKS.
  - The invulnerability counter decrements once per tick in every state.
- Death: if an accepted hit leaves `hp` = 0, go to DEAD on the next cycle. Death takes priority over a pattern-end transition on the same cycle.
- Edges of `isCollide` outside RUN are discarded. An edge during invulnerability is discarded, not queued.
- HP arithmetic is 8-bit unsigned and saturates at 0. No underflow wrap.

## Timing
- Reset values: state IDLE, `index1` = `index2` = 0, `isRun` = 0, `bulletCollide` = `hitPulse` = 0, `hp` = MAX_HP, `done` = `dead` = 0, all counters 0.
- `start` at cycle n → ARM at n+1 → `isRun` = 1 from n+2.
- Pattern timing:
  - A pattern lasts PATTERN_TICKS ticks.
  - The tick phase restarts at ARM, so the first tick arrives TICK_DIV cycles after RUN is entered.
- `isCollide` rising at cycle n (registered) → `hitPulse`, `bulletCollide` and the new `hp` all at n+1.
- DEAD is entered at n+2; `isRun` falls in the same cycle.
- Asserting `reset` mid-phase forces the reset values immediately, with no clock edge needed.
- `start` arriving on the same cycle as DONE entry is ignored. It takes effect only once the FSM is in DONE.

## Structure
- Package `scheduler_pkg` holds:
  - the state enum (3-bit encoding);
  - the HP width (8) and pattern-index width (3) constants.
- Sub-module `tick_divider` (parameter TICK_DIV): a free-running prescaler with a synchronous `clear` input, emitting a one-cycle `tick`.
- All other logic lives in `attack_scheduler`.

## Test plan
Bench parameters: TICK_DIV=4, PATTERN_TICKS=10, GAP_TICKS=2, NUM_PATTERNS=3, MAX_HP=20, DAMAGE=5, INVULN_TICKS=6.
- Reset released, no stimulus → outputs hold their reset values, including `hp` = 20.
- `start` pulse → `isRun` = 1 two cycles later with indices 0/1.
  - Patterns (0,1), (1,2), (2,0) each run 40 cycles, separated by 8-cycle gaps with `isRun` = 0.
  - `done` = 1 afterwards.
- `isCollide` held high for 100 cycles in RUN → exactly one hit, `hp` = 15.
- A second rising edge 12 cycles later (inside the 24-cycle invulnerability window) → ignored.
- A rising edge after 30 cycles → `hp` = 10.
- Four hits spaced 30 cycles apart → `hp` steps 15, 10, 5, 0.
  - DEAD is entered, `dead` = 1, `isRun` = 0.
  - Later `isCollide` edges do not change `hp`.
- `isCollide` edges during GAP and in DONE → no `hitPulse`, `hp` unchanged.
- `reset` asserted mid-RUN of pattern 1 with `hp` = 10 → immediate IDLE, `hp` = 20, `isRun` = 0.
  - A following `start` restarts the phase at pattern 0.
